clint_timer: RTL
================

# clint_timer

Machine-level timer and software-interrupt unit sitting directly upstream of the CSR register file. It owns the 64-bit `mtime` and `mtimecmp` registers and the `msip` bit, and exposes them through a single-outstanding memory-mapped request/response port. It drives the `Timer_interrupt` and `Soft_interrupt` request lines, which the CSR file samples into `mip.MTIP` and `mip.MSIP`.

## Interface
- `TICK_DIV`, 1: clk cycles per `mtime` increment; legal range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 3: word offset. 0 = `msip`, 1 = `mtimecmp[31:0]`, 2 = `mtimecmp[63:32]`, 3 = `mtime[31:0]`, 4 = `mtime[63:32]`. Offsets 5-7 are unmapped.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed when `resp_valid && resp_ready`.
- `resp_rdata` out 32: read data; 0 for writes.
- `resp_err` out 1: access was to an unmapped offset.
- `time_halt` in 1: freezes the prescaler and `mtime` (debug halt).
- `Soft_interrupt` out 1: equals `msip[0]`.
- `Timer_interrupt` out 1: registered result of unsigned `mtime >= mtimecmp`.

## Operation
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, prescaler = 0.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - `Timer_interrupt` = 0, `Soft_interrupt` = 0.
  - `req_ready` = 1 during the first cycle after reset.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 while `time_halt` = 0; a tick fires when it wraps from `TICK_DIV`-1 to 0.
  - `TICK_DIV` = 1 gives a tick every cycle.
  - `time_halt` holds both the prescaler and `mtime`.
- `mtime`:
  - Increments by 1 on each tick, 64-bit unsigned.
  - Wraps from all-ones to 0 with no flag.
- Writes:
  - `msip` stores only `req_wdata[0]`; bits 31:1 read as 0.
  - A half-word write to `mtime` or `mtimecmp` replaces only that 32-bit half. There is no carry or borrow into the other half.
- Simultaneous events: a bus write to either `mtime` half in the same cycle as a tick wins. `mtime` takes the written half, the other half is held, and that tick is lost; the prescaler still advances.
- Reads: return the register value in the acceptance cycle, before any same-cycle update.
- Unmapped offsets: reads return 0, writes are dropped, and `resp_err` = 1.
- Handshake FSM, two states:
  - **IDLE**: `req_ready` = 1, `resp_valid` = 0. An accepted request goes to **RESP**.
  - **RESP**: `resp_valid` = 1 and `resp_rdata`/`resp_err` are held stable.
    - `resp_ready` = 1 with no new request: go to IDLE.
    - `resp_ready` = 1 with a new request: accept it the same cycle (`req_ready` = `resp_ready` in RESP) and stay in RESP with the new data.
    - `resp_ready` = 0: stay in RESP.

## Timing
- Request-to-response latency is 1 cycle. Back-to-back throughput is 1 request per cycle while `resp_ready` = 1.
- Register side effects of a write are visible on the cycle after acceptance.
- `Timer_interrupt` is registered: it reflects the compare of `mtime`/`mtimecmp` values from the previous cycle. It therefore asserts 1 cycle after `mtime` reaches `mtimecmp`, or 1 cycle after a write makes the compare true.
- `Timer_interrupt` is level, not pulse. It is cleared only by raising `mtimecmp` or writing `mtime`, never by the CSR file.
- `Soft_interrupt` updates 1 cycle after the `msip` write is accepted.
- Reset asserted mid-transaction: the response is discarded, the FSM returns to IDLE, and all registers take their reset values on that edge.

## Structure
- Package `clint_pkg` holds:
  - offset constants `CLINT_MSIP`, `CLINT_CMP_LO`, `CLINT_CMP_HI`, `CLINT_TIME_LO`, `CLINT_TIME_HI`;
  - FSM state enum `clint_st_t` (IDLE, RESP);
  - `MTIMECMP_RST` constant.
- One sub-module, `clint_prescaler` (parameter `TICK_DIV`; inputs `clk`, `rst`, `time_halt`; output `tick`), holds the 16-bit divider counter.
- The top level holds the registers, the compare, and the FSM.

## Test plan
- Reset, then `TICK_DIV` = 4, 40 idle cycles: read offset 3 returns 10; `Timer_interrupt` stays 0.
- Write `mtimecmp` hi = 0, then lo = 5, with `TICK_DIV` = 1: `Timer_interrupt` rises exactly 1 cycle after `mtime` = 5. Writing lo = 0xFFFF_FFFF drops it 2 cycles after acceptance.
- Write `mtime` hi = 0xFFFF_FFFF, lo = 0xFFFF_FFFE, `TICK_DIV` = 1: `mtime` wraps to 0 two ticks later; a hi read returns 0.
- Write offset 3 in the same cycle as a tick with `mtime` lo = 7 and data 0x100: the next read returns 0x100, not 0x101.
- Write offset 0 with data 0x3: `Soft_interrupt` = 1 next cycle and a read returns 0x1. Write 0: `Soft_interrupt` drops.
- Read offset 6 while holding `resp_ready` = 0 for 3 cycles: `resp_valid` held, `resp_err` = 1, `resp_rdata` = 0, `req_ready` = 0 until the response is consumed.

Source files
------------

// File: rtl/clint_pkg.sv
// clint_pkg: shared definitions for the machine timer / software-interrupt unit.
//   - word offsets of the memory-mapped registers
//   - handshake FSM state type
//   - reset value of mtimecmp
//   - helper telling whether an offset maps to a register
package clint_pkg;

  localparam logic [2:0] CLINT_MSIP    = 3'd0;
  localparam logic [2:0] CLINT_CMP_LO  = 3'd1;
  localparam logic [2:0] CLINT_CMP_HI  = 3'd2;
  localparam logic [2:0] CLINT_TIME_LO = 3'd3;
  localparam logic [2:0] CLINT_TIME_HI = 3'd4;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_st_t;

  // Offsets above CLINT_TIME_HI are unmapped.
  function automatic logic clint_addr_mapped(input logic [2:0] addr);
    return (addr <= CLINT_TIME_HI);
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk down to the mtime increment rate.
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-high reset
//   time_halt in  : freezes the divider (debug halt)
//   tick      out : one-cycle pulse when the divider wraps TICK_DIV-1 -> 0
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic time_halt,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 32'd1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        wrap_s;

  // Next divider value and the wrap pulse; a halted divider neither moves nor ticks.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_s = 1'b0;
    if (time_halt) begin
      cnt_d  = cnt_q;
      wrap_s = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d  = 16'd0;
      wrap_s = 1'b1;
    end else begin
      cnt_d  = cnt_q + 16'd1;
      wrap_s = 1'b0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = wrap_s;

endmodule

// File: rtl/clint_timer.sv
// clint_timer: mtime/mtimecmp/msip registers behind a single-outstanding
// request/response port, driving the machine timer and software interrupts.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready/req_we     : request handshake and direction
//   req_addr, req_wdata            : word offset and write data
//   resp_valid/resp_ready          : response handshake
//   resp_rdata, resp_err           : read data (0 for writes), unmapped-offset flag
//   time_halt                      : freezes prescaler and mtime
//   Soft_interrupt, Timer_interrupt: interrupt request levels
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        time_halt,
  output logic        Soft_interrupt,
  output logic        Timer_interrupt
);

  clint_st_t   state_q;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        tick_s;
  logic        accept_s;
  logic        mapped_s;
  logic [31:0] rdata_s;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .time_halt (time_halt),
    .tick      (tick_s)
  );

  // In RESP a new request can only enter when the current response leaves.
  assign req_ready  = (state_q == ST_IDLE) || resp_ready;
  assign accept_s   = req_valid && req_ready;
  assign mapped_s   = clint_addr_mapped(req_addr);
  assign resp_valid = (state_q == ST_RESP);

  // Read mux over the pre-update register values.
  always_comb begin
    rdata_s = 32'd0;
    case (req_addr)
      CLINT_MSIP:    rdata_s = {31'd0, msip_q};
      CLINT_CMP_LO:  rdata_s = mtimecmp_q[31:0];
      CLINT_CMP_HI:  rdata_s = mtimecmp_q[63:32];
      CLINT_TIME_LO: rdata_s = mtime_q[31:0];
      CLINT_TIME_HI: rdata_s = mtime_q[63:32];
      default:       rdata_s = 32'd0;
    endcase
  end

  // Register next state: a bus write to an mtime half overrides (and loses) a same-cycle tick.
  always_comb begin
    mtime_d    = tick_s ? (mtime_q + 64'd1) : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (accept_s && req_we) begin
      case (req_addr)
        CLINT_MSIP:    msip_d             = req_wdata[0];
        CLINT_CMP_LO:  mtimecmp_d[31:0]   = req_wdata;
        CLINT_CMP_HI:  mtimecmp_d[63:32]  = req_wdata;
        CLINT_TIME_LO: mtime_d            = {mtime_q[63:32], req_wdata};
        CLINT_TIME_HI: mtime_d            = {req_wdata, mtime_q[31:0]};
        default:       msip_d             = msip_q;
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Timer state and the registered compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= MTIMECMP_RST;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  // Handshake FSM with its registered response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= accept_s ? ST_RESP : ST_IDLE;
        ST_RESP: begin
          if (accept_s) begin
            state_q <= ST_RESP;
          end else if (resp_ready) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (accept_s) begin
        resp_rdata_q <= req_we ? 32'd0 : rdata_s;
        resp_err_q   <= !mapped_s;
      end else begin
        resp_rdata_q <= resp_rdata_q;
        resp_err_q   <= resp_err_q;
      end
    end
  end

  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;
  assign Soft_interrupt  = msip_q;
  assign Timer_interrupt = timer_irq_q;

endmodule
